mem_req_ctrl: RTL
=================

// Module: mem_req_ctrl
// PURPOSE
//  Initiator side of the stalling-memory interface (Rd/Wr/Addr/DataIn -> DataOut/Done/Stall/err).
//  Accepts one request at a time from a pipeline stage (fetch or mem) over a valid/ready handshake.
//  Drives the memory, holds the request stable through Stall cycles, and captures read data on Done.
//  Returns a one-cycle response carrying data and error status. Sits between a pipeline stage and stallmem.
// PARAMETERS
//  AW             16   address width (byte address)
//  DW             16   data width
//  TIMEOUT_CYCLES 255  stall cycles before abort (used only with MEM_REQ_TIMEOUT_EN)
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous reset, active-high
//  req_valid    in   1   request present
//  req_ready    out  1   controller can accept a request this cycle
//  req_wr       in   1   1=write, 0=read
//  req_addr     in   AW  byte address
//  req_wdata    in   DW  write data
//  resp_valid   out  1   one-cycle response pulse
//  resp_rdata   out  DW  read data (0 for writes and errors)
//  resp_err     out  1   memory err or timeout
//  resp_timeout out  1   response caused by timeout (0 when macro absent)
//  stall_cycles out  16  saturating count of cycles the memory reported Stall
//  mem_Rd       out  1   to memory Rd
//  mem_Wr       out  1   to memory Wr
//  mem_Addr     out  AW  to memory Addr
//  mem_DataIn   out  DW  to memory DataIn
//  mem_DataOut  in   DW  from memory DataOut (combinational, valid when mem_Done)
//  mem_Done     in   1   access completed this cycle
//  mem_Stall    in   1   access not taken; retry
//  mem_err      in   1   misaligned access flagged by memory
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; resp_valid/resp_err/resp_timeout=0; resp_rdata=0; mem_Rd=mem_Wr=0;
//   mem_Addr=mem_DataIn=0; stall_cycles=0.
//  FSM: IDLE -> ACCESS on req_valid&req_ready. ACCESS -> RESP on mem_Done (or timeout). RESP -> ACCESS if a new
//   request is accepted in RESP, else -> IDLE.
//  req_ready=1 in IDLE and RESP only (back-to-back issue allowed); 0 in ACCESS.
//  Request regs load at the accept edge; mem_Rd=~wr, mem_Wr=wr asserted for the whole ACCESS state, never both.
//  Addr/DataIn/Rd/Wr are held bit-stable for every ACCESS cycle, including Stall cycles.
//  On mem_Done in ACCESS: register mem_DataOut (reads) and mem_err; the next cycle is RESP with resp_valid=1.
//  Minimum latency: accept at edge N, Done sampled in cycle N+1, resp_valid high in cycle N+2.
//  Write responses: resp_rdata=0. Error responses: resp_rdata=0, resp_err=1.
//  Done=0 and Stall=0 while Rd|Wr: treated as Stall (keep waiting), stall_cycles not incremented.
//  stall_cycles: +1 per ACCESS cycle with mem_Stall; saturates at 16'hFFFF; cleared only by rst.
//  rst mid-ACCESS: all outputs return to reset values at that edge; a write with Done in that cycle commits.
//  Misalignment is not prechecked; the address is passed unchanged and memory err is reported.
// CONFIGURATION
//  MEM_REQ_TIMEOUT_EN defined:
//   - A per-access counter counts ACCESS cycles.
//   - Reaching TIMEOUT_CYCLES without Done drops Rd/Wr and goes to RESP with resp_err=1 and resp_timeout=1.
//   - The counter clears at each accept.
//  MEM_REQ_TIMEOUT_EN undefined:
//   - Waits indefinitely.
//   - resp_timeout is tied to 0; the counter is not instantiated.
// STRUCTURE
//  Package mem_req_pkg:
//   - State encodings IDLE/ACCESS/RESP (2-bit localparams).
//   - Default AW/DW.
//   - Stall counter width (16).
//  Sub-module mem_req_timeout (counter + expiry compare), instantiated only under MEM_REQ_TIMEOUT_EN.
// TESTING
//  1. Read 0x0010, memory Done immediately, DataOut=0xBEEF -> resp_valid 2 cycles after accept,
//     resp_rdata=0xBEEF, resp_err=0.
//  2. Write 0x0020=0x1234 with 3 Stall cycles -> mem_Addr/DataIn/Wr stable for 4 cycles, resp_valid once,
//     stall_cycles=3.
//  3. Read odd address 0x0021 -> memory err -> resp_err=1, resp_rdata=0.
//  4. Back-to-back: req_valid held with 2 requests -> second accepted in RESP cycle; no idle bubble on mem_Rd.
//  5. rst asserted during a stalled ACCESS -> next cycle mem_Rd=mem_Wr=0, req_ready=1, resp_valid=0, stall_cycles=0.
//  6. With MEM_REQ_TIMEOUT_EN, TIMEOUT_CYCLES=4, permanent Stall -> resp_valid with resp_err=1, resp_timeout=1
//     after 4 ACCESS cycles.

Source files
------------

// File: rtl/mem_req_pkg.sv
// Shared types and sizes for the memory request controller.
package mem_req_pkg;

  localparam int unsigned DEFAULT_AW  = 16;
  localparam int unsigned DEFAULT_DW  = 16;
  localparam int unsigned STALL_CNT_W = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ACCESS = ST_ACCESS,
    RESP   = ST_RESP
  } state_t;

endpackage

// File: rtl/mem_req_timeout.sv
// Per-access cycle counter; flags the ACCESS cycle on which the limit is reached.
// Only instantiated when MEM_REQ_TIMEOUT_EN is defined.
module mem_req_timeout #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic active,
  output logic expired_c
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  // Count ACCESS cycles, restarting at every accepted request.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (active && (cnt != CW'(LIMIT))) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired_c = active && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_req_ctrl.sv
// Initiator for the stalling memory: accepts one request over valid/ready,
// holds it on the memory bus until Done, and returns a one-cycle response.
// Optional abort on a stuck access: define MEM_REQ_TIMEOUT_EN.
module mem_req_ctrl
  import mem_req_pkg::*;
#(
  parameter int unsigned AW             = DEFAULT_AW,
  parameter int unsigned DW             = DEFAULT_DW,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_wr,
  input  logic [AW-1:0]          req_addr,
  input  logic [DW-1:0]          req_wdata,
  output logic                   resp_valid,
  output logic [DW-1:0]          resp_rdata,
  output logic                   resp_err,
  output logic                   resp_timeout,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic                   mem_Rd,
  output logic                   mem_Wr,
  output logic [AW-1:0]          mem_Addr,
  output logic [DW-1:0]          mem_DataIn,
  input  logic [DW-1:0]          mem_DataOut,
  input  logic                   mem_Done,
  input  logic                   mem_Stall,
  input  logic                   mem_err
);

  state_t state;
  logic   accept_c;
  logic   timeout_c;

  assign accept_c = req_valid && (state != ACCESS);

`ifdef MEM_REQ_TIMEOUT_EN
  mem_req_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept_c),
    .active    (state == ACCESS),
    .expired_c (timeout_c)
  );
`else
  // Without the timeout option the access waits forever.
  assign timeout_c = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  // Request FSM with registered memory-side and response-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      resp_timeout <= 1'b0;
      stall_cycles <= '0;
      mem_Rd       <= 1'b0;
      mem_Wr       <= 1'b0;
      mem_Addr     <= '0;
      mem_DataIn   <= '0;
    end else begin
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      resp_timeout <= 1'b0;

      if ((state == ACCESS) && mem_Stall && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + STALL_CNT_W'(1);
      end

      case (state)
        IDLE, RESP: begin
          if (accept_c) begin
            state      <= ACCESS;
            req_ready  <= 1'b0;
            mem_Rd     <= ~req_wr;
            mem_Wr     <= req_wr;
            mem_Addr   <= req_addr;
            mem_DataIn <= req_wdata;
          end else begin
            state     <= IDLE;
            req_ready <= 1'b1;
            mem_Rd    <= 1'b0;
            mem_Wr    <= 1'b0;
          end
        end
        ACCESS: begin
          // Neither Done nor Stall is treated like a stall: keep the bus as is.
          if (mem_Done) begin
            state      <= RESP;
            req_ready  <= 1'b1;
            resp_valid <= 1'b1;
            resp_err   <= mem_err;
            resp_rdata <= (mem_Rd && !mem_err) ? mem_DataOut : '0;
            mem_Rd     <= 1'b0;
            mem_Wr     <= 1'b0;
          end else if (timeout_c) begin
            state        <= RESP;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b1;
            resp_err     <= 1'b1;
            resp_timeout <= 1'b1;
            mem_Rd       <= 1'b0;
            mem_Wr       <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          mem_Rd    <= 1'b0;
          mem_Wr    <= 1'b0;
        end
      endcase
    end
  end

endmodule
